stall_ctrl: RTL and testbench

STALL_CTRL -- requirements
Module: stall_ctrl

---
 rtl/stall_ctrl.sv | 130 +++++++++++++
 tb/tb_stall_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stall_ctrl.sv
// -----------------------------------------------------------------------------
// stall_ctrl -- pipeline hazard / data-cache miss stall controller
//
// Combines two stall sources for a 5-stage pipeline:
//   * load-use hazard detection (ID vs EX) -> one-cycle bubble
//   * data-cache miss handling FSM (IDLE -> [WB] -> REFILL -> DONE -> IDLE)
//     which freezes the whole pipeline until the line is refilled.
//
// Ports
//   clk_i, rst_i              clock, asynchronous active-low reset
//   IDEX_MemRead_i            EX-stage instruction is a load
//   IDEX_RDaddr_i             EX-stage destination register
//   IFID_RS1addr_i/RS2addr_i  ID-stage source registers
//   Branch_i                  taken branch resolved in ID
//   EXMEM_MemRead_i/MemWrite_i MEM-stage data access
//   hit_i, dirty_i            cache hit / victim dirty for the MEM access
//   mem_ack_i                 off-chip transfer complete (1-cycle pulse)
//   PCWrite_o, IFIDWrite_o    PC / IF-ID update enables
//   NoOp_o                    insert bubble into ID/EX
//   Flush_o                   clear IF/ID
//   MemStall_o                freeze all pipeline registers
//   mem_req_o, mem_we_o       memory request, write (1) / read (0)
//   refill_we_o               write refill data into the cache array
//   stall_cnt_o, miss_cnt_o   saturating performance counters
// -----------------------------------------------------------------------------
module stall_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        IDEX_MemRead_i,
  input  logic [4:0]  IDEX_RDaddr_i,
  input  logic [4:0]  IFID_RS1addr_i,
  input  logic [4:0]  IFID_RS2addr_i,
  input  logic        Branch_i,
  input  logic        EXMEM_MemRead_i,
  input  logic        EXMEM_MemWrite_i,
  input  logic        hit_i,
  input  logic        dirty_i,
  input  logic        mem_ack_i,
  output logic        PCWrite_o,
  output logic        IFIDWrite_o,
  output logic        NoOp_o,
  output logic        Flush_o,
  output logic        MemStall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        refill_we_o,
  output logic [15:0] stall_cnt_o,
  output logic [15:0] miss_cnt_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WB     = 2'd1,
    REFILL = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   miss;
  logic   hazard;

  // A miss is only meaningful while idle; in the other states the access
  // is already being serviced and is re-evaluated once back in IDLE.
  assign miss = (state_q == IDLE) & (EXMEM_MemRead_i | EXMEM_MemWrite_i) & ~hit_i;

  assign hazard = IDEX_MemRead_i & (IDEX_RDaddr_i != 5'd0) &
                  ((IDEX_RDaddr_i == IFID_RS1addr_i) |
                   (IDEX_RDaddr_i == IFID_RS2addr_i));

  // NOTE: non-blocking assignments for all clocked state so every register
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (miss) state_d = dirty_i ? WB : REFILL;
      WB:      if (mem_ack_i) state_d = REFILL;
      REFILL:  if (mem_ack_i) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory-side outputs decode the state register only, so an asynchronous
  // reset drops them immediately, without waiting for a clock edge.
  always_comb begin
    mem_req_o   = (state_q == WB) | (state_q == REFILL);
    mem_we_o    = (state_q == WB);
    refill_we_o = (state_q == DONE);
  end

  // Pipeline control: a memory stall overrides the load-use hazard; the
  // hazard is simply seen again once the freeze lifts.
  always_comb begin
    MemStall_o  = (state_q != IDLE) | miss;
    PCWrite_o   = 1'b1;
    IFIDWrite_o = 1'b1;
    NoOp_o      = 1'b0;
    if (MemStall_o) begin
      PCWrite_o   = 1'b0;
      IFIDWrite_o = 1'b0;
    end else if (hazard) begin
      PCWrite_o   = 1'b0;
      IFIDWrite_o = 1'b0;
      NoOp_o      = 1'b1;
    end
    Flush_o = Branch_i & ~hazard & ~MemStall_o;
  end

  // Saturating performance counters.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o <= '0;
      miss_cnt_o  <= '0;
    end else begin
      if (MemStall_o && (stall_cnt_o != 16'hFFFF))
        stall_cnt_o <= stall_cnt_o + 16'd1;
      // miss is gated by IDLE, so it marks exactly the IDLE->WB/REFILL edge.
      if (miss && (miss_cnt_o != 16'hFFFF))
        miss_cnt_o <= miss_cnt_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stall_ctrl -- self-checking bench for stall_ctrl
//
// Each scenario task drives inputs on the falling edge, pushes the expected
// control-output vector to a scoreboard queue, and pops/compares it 1 ns
// later (well away from the rising edge). Expected vectors are hand-derived
// constants; counter expectations are tracked in bench variables.
// Vector bit order: {PCWrite, IFIDWrite, NoOp, Flush, MemStall,
//                    mem_req, mem_we, refill_we}
// -----------------------------------------------------------------------------
module tb_stall_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        IDEX_MemRead_i;
  logic [4:0]  IDEX_RDaddr_i;
  logic [4:0]  IFID_RS1addr_i;
  logic [4:0]  IFID_RS2addr_i;
  logic        Branch_i;
  logic        EXMEM_MemRead_i;
  logic        EXMEM_MemWrite_i;
  logic        hit_i;
  logic        dirty_i;
  logic        mem_ack_i;
  logic        PCWrite_o;
  logic        IFIDWrite_o;
  logic        NoOp_o;
  logic        Flush_o;
  logic        MemStall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic        refill_we_o;
  logic [15:0] stall_cnt_o;
  logic [15:0] miss_cnt_o;

  stall_ctrl dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .IDEX_MemRead_i   (IDEX_MemRead_i),
    .IDEX_RDaddr_i    (IDEX_RDaddr_i),
    .IFID_RS1addr_i   (IFID_RS1addr_i),
    .IFID_RS2addr_i   (IFID_RS2addr_i),
    .Branch_i         (Branch_i),
    .EXMEM_MemRead_i  (EXMEM_MemRead_i),
    .EXMEM_MemWrite_i (EXMEM_MemWrite_i),
    .hit_i            (hit_i),
    .dirty_i          (dirty_i),
    .mem_ack_i        (mem_ack_i),
    .PCWrite_o        (PCWrite_o),
    .IFIDWrite_o      (IFIDWrite_o),
    .NoOp_o           (NoOp_o),
    .Flush_o          (Flush_o),
    .MemStall_o       (MemStall_o),
    .mem_req_o        (mem_req_o),
    .mem_we_o         (mem_we_o),
    .refill_we_o      (refill_we_o),
    .stall_cnt_o      (stall_cnt_o),
    .miss_cnt_o       (miss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [7:0] RUN       = 8'b1100_0000;
  localparam logic [7:0] RUN_FLUSH = 8'b1101_0000;
  localparam logic [7:0] HAZ       = 8'b0010_0000;
  localparam logic [7:0] MISS_IDLE = 8'b0000_1000;
  localparam logic [7:0] WB_S      = 8'b0000_1110;
  localparam logic [7:0] REFILL_S  = 8'b0000_1100;
  localparam logic [7:0] DONE_S    = 8'b0000_1001;

  typedef struct {
    logic [7:0] v;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   passed = 0;
  int   total  = 0;
  int   exp_stall = 0;
  int   exp_miss  = 0;

  function automatic logic [7:0] obs();
    return {PCWrite_o, IFIDWrite_o, NoOp_o, Flush_o,
            MemStall_o, mem_req_o, mem_we_o, refill_we_o};
  endfunction

  task automatic push(input string n, input logic [7:0] v);
    exp_t e;
    e.v    = v;
    e.name = n;
    exp_q.push_back(e);
  endtask

  task automatic clear_inputs();
    IDEX_MemRead_i   = 1'b0;
    IDEX_RDaddr_i    = 5'd0;
    IFID_RS1addr_i   = 5'd0;
    IFID_RS2addr_i   = 5'd0;
    Branch_i         = 1'b0;
    EXMEM_MemRead_i  = 1'b0;
    EXMEM_MemWrite_i = 1'b0;
    hit_i            = 1'b1;
    dirty_i          = 1'b0;
    mem_ack_i        = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    exp_t e;
    clear_inputs();
    rst_i = 1'b0;
    #2;
    push("reset_outputs", RUN);
    e = exp_q.pop_front();
    total++;
    if (obs() !== e.v) $display("FAIL %s: got %b expected %b", e.name, obs(), e.v);
    else passed++;
    total++;
    if (stall_cnt_o !== 16'd0 || miss_cnt_o !== 16'd0)
      $display("FAIL reset_counters: got stall=%0d miss=%0d expected 0/0", stall_cnt_o, miss_cnt_o);
    else passed++;
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  typedef struct {
    logic       rd_en;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       br;
    logic [7:0] v;
    string      name;
  } lu_t;

  task automatic test_load_use();
    lu_t  tbl[$];
    exp_t e;
    tbl.push_back('{1'b1, 5'd5,  5'd7,  5'd5,  1'b0, HAZ,       "load_use_rs2"});
    tbl.push_back('{1'b1, 5'd0,  5'd0,  5'd0,  1'b0, RUN,       "load_use_rd0"});
    tbl.push_back('{1'b1, 5'd9,  5'd9,  5'd3,  1'b0, HAZ,       "load_use_rs1"});
    tbl.push_back('{1'b0, 5'd9,  5'd9,  5'd9,  1'b0, RUN,       "no_load_no_haz"});
    tbl.push_back('{1'b1, 5'd4,  5'd1,  5'd2,  1'b0, RUN,       "load_no_match"});
    tbl.push_back('{1'b1, 5'd12, 5'd12, 5'd12, 1'b1, HAZ,       "branch_with_haz"});
    tbl.push_back('{1'b0, 5'd0,  5'd0,  5'd0,  1'b1, RUN_FLUSH, "branch_no_haz"});
    foreach (tbl[i]) begin
      @(negedge clk_i);
      IDEX_MemRead_i = tbl[i].rd_en;
      IDEX_RDaddr_i  = tbl[i].rd;
      IFID_RS1addr_i = tbl[i].rs1;
      IFID_RS2addr_i = tbl[i].rs2;
      Branch_i       = tbl[i].br;
      push(tbl[i].name, tbl[i].v);
      #1;
      e = exp_q.pop_front();
      total++;
      if (obs() !== e.v) $display("FAIL %s: got %b expected %b", e.name, obs(), e.v);
      else passed++;
    end
    @(negedge clk_i);
    clear_inputs();
  endtask

  // ---------------------------------------------------------------------------
  // Clean read miss, with a branch and a load-use hazard pending throughout
  // the stall: neither may flush nor bubble while frozen.
  task automatic test_clean_miss();
    exp_t e;
    @(negedge clk_i);
    EXMEM_MemRead_i = 1'b1;
    hit_i           = 1'b0;
    dirty_i         = 1'b0;
    Branch_i        = 1'b1;
    IDEX_MemRead_i  = 1'b1;
    IDEX_RDaddr_i   = 5'd5;
    IFID_RS1addr_i  = 5'd5;
    push("cm_detect", MISS_IDLE);
    #1;
    e = exp_q.pop_front();
    total++;
    if (obs() !== e.v) $display("FAIL %s: got %b expected %b", e.name, obs(), e.v);
    else passed++;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk_i);
      mem_ack_i = (i == 10);
      push($sformatf("cm_refill_%0d", i), REFILL_S);
      #1;
      e = exp_q.pop_front();
      total++;
      if (obs() !== e.v) $display("FAIL %s: got %b expected %b", e.name, obs(), e.v);
      else passed++;
    end
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    push("cm_done", DONE_S);
    #1;
    e = exp_q.pop_front();
    total++;
    if (obs() !== e.v) $display("FAIL %s: got %b expected %b", e.name, obs(), e.v);
    else passed++;
    @(negedge clk_i);
    hit_i          = 1'b1;
    Branch_i       = 1'b0;
    IDEX_MemRead_i = 1'b0;
    push("cm_idle_hit", RUN);
    #1;
    e = exp_q.pop_front();
    total++;
    if (obs() !== e.v) $display("FAIL %s: got %b expected %b", e.name, obs(), e.v);
    else passed++;
    exp_stall += 12;
    exp_miss  += 1;
    total++;
    if (stall_cnt_o !== exp_stall[15:0] || miss_cnt_o !== exp_miss[15:0])
      $display("FAIL cm_counters: got stall=%0d miss=%0d expected %0d/%0d",
               stall_cnt_o, miss_cnt_o, exp_stall, exp_miss);
    else passed++;
    // Branch after the stall, no hazard: flush now allowed.
    @(negedge clk_i);
    EXMEM_MemRead_i = 1'b0;
    Branch_i        = 1'b1;
    push("branch_after_stall", RUN_FLUSH);
    #1;
    e = exp_q.pop_front();
    total++;
    if (obs() !== e.v) $display("FAIL %s: got %b expected %b", e.name, obs(), e.v);
    else passed++;
    @(negedge clk_i);
    clear_inputs();
  endtask

  // ---------------------------------------------------------------------------
  // Dirty write miss: WB for 3 cycles, REFILL for 2, DONE, back to IDLE.
  task automatic test_dirty_miss();
    exp_t e;
    @(negedge clk_i);
    EXMEM_MemWrite_i = 1'b1;
    hit_i            = 1'b0;
    dirty_i          = 1'b1;
    push("dm_detect", MISS_IDLE);
    #1;
    e = exp_q.pop_front();
    total++;
    if (obs() !== e.v) $display("FAIL %s: got %b expected %b", e.name, obs(), e.v);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      mem_ack_i = (i == 2) || (i == 4);
      push($sformatf("dm_xfer_%0d", i), (i < 3) ? WB_S : REFILL_S);
      #1;
      e = exp_q.pop_front();
      total++;
      if (obs() !== e.v) $display("FAIL %s: got %b expected %b", e.name, obs(), e.v);
      else passed++;
    end
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    push("dm_done", DONE_S);
    #1;
    e = exp_q.pop_front();
    total++;
    if (obs() !== e.v) $display("FAIL %s: got %b expected %b", e.name, obs(), e.v);
    else passed++;
    @(negedge clk_i);
    hit_i = 1'b1;
    push("dm_idle_hit", RUN);
    #1;
    e = exp_q.pop_front();
    total++;
    if (obs() !== e.v) $display("FAIL %s: got %b expected %b", e.name, obs(), e.v);
    else passed++;
    exp_stall += 7;
    exp_miss  += 1;
    total++;
    if (stall_cnt_o !== exp_stall[15:0] || miss_cnt_o !== exp_miss[15:0])
      $display("FAIL dm_counters: got stall=%0d miss=%0d expected %0d/%0d",
               stall_cnt_o, miss_cnt_o, exp_stall, exp_miss);
    else passed++;
    @(negedge clk_i);
    clear_inputs();
  endtask

  // ---------------------------------------------------------------------------
  // Asynchronous reset in the middle of REFILL, then a spurious ack in IDLE.
  task automatic test_reset_mid_refill();
    exp_t e;
    @(negedge clk_i);
    EXMEM_MemRead_i = 1'b1;
    hit_i           = 1'b0;
    repeat (4) @(negedge clk_i);
    #2;
    total++;
    if (mem_req_o !== 1'b1)
      $display("FAIL rr_in_refill: got mem_req=%b expected 1", mem_req_o);
    else passed++;
    rst_i = 1'b0;
    #1;
    // Miss inputs still present: in reset the IDLE equations apply.
    push("rr_async", MISS_IDLE);
    e = exp_q.pop_front();
    total++;
    if (obs() !== e.v) $display("FAIL %s: got %b expected %b", e.name, obs(), e.v);
    else passed++;
    exp_stall = 0;
    exp_miss  = 0;
    total++;
    if (stall_cnt_o !== 16'd0 || miss_cnt_o !== 16'd0)
      $display("FAIL rr_counters: got stall=%0d miss=%0d expected 0/0", stall_cnt_o, miss_cnt_o);
    else passed++;
    @(negedge clk_i);
    rst_i           = 1'b1;
    EXMEM_MemRead_i = 1'b0;
    hit_i           = 1'b1;
    mem_ack_i       = 1'b1;
    push("rr_ack_in_idle", RUN);
    #1;
    e = exp_q.pop_front();
    total++;
    if (obs() !== e.v) $display("FAIL %s: got %b expected %b", e.name, obs(), e.v);
    else passed++;
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    push("rr_after_ack", RUN);
    #1;
    e = exp_q.pop_front();
    total++;
    if (obs() !== e.v) $display("FAIL %s: got %b expected %b", e.name, obs(), e.v);
    else passed++;
    total++;
    if (stall_cnt_o !== 16'd0 || miss_cnt_o !== 16'd0)
      $display("FAIL rr_counters_after: got stall=%0d miss=%0d expected 0/0", stall_cnt_o, miss_cnt_o);
    else passed++;
  endtask

  // ---------------------------------------------------------------------------
  // Hold REFILL (no ack) long enough to saturate the stall counter.
  task automatic test_saturation();
    exp_t e;
    @(negedge clk_i);
    EXMEM_MemRead_i = 1'b1;
    hit_i           = 1'b0;
    repeat (65540) @(negedge clk_i);
    #1;
    push("sat_refill", REFILL_S);
    e = exp_q.pop_front();
    total++;
    if (obs() !== e.v) $display("FAIL %s: got %b expected %b", e.name, obs(), e.v);
    else passed++;
    total++;
    if (stall_cnt_o !== 16'hFFFF)
      $display("FAIL sat_stall_cnt: got %h expected ffff", stall_cnt_o);
    else passed++;
    total++;
    if (miss_cnt_o !== 16'd1)
      $display("FAIL sat_miss_cnt: got %0d expected 1", miss_cnt_o);
    else passed++;
    repeat (3) @(negedge clk_i);
    #1;
    total++;
    if (stall_cnt_o !== 16'hFFFF)
      $display("FAIL sat_hold: got %h expected ffff", stall_cnt_o);
    else passed++;
    rst_i = 1'b0;
    clear_inputs();
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_clean_miss();
    test_dirty_miss();
    test_reset_mid_refill();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
